adma_descriptor_fetch: RTL and testbench
========================================

ADMA_DESCRIPTOR_FETCH -- requirements
Module: adma_descriptor_fetch

Interface
REQ-001 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port RESET  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port STOP  input  1  level; abort and pause the descriptor walk.
REQ-004 SHALL have port command_reg_write  input  1  single-cycle start pulse; walk begins at starting_address.
REQ-005 SHALL have port command_reg_continue  input  1  single-cycle resume pulse after a pause.
REQ-006 SHALL have port starting_address  input  64  byte address of first descriptor.
REQ-007 SHALL have port mem_req  output  1  memory read request, held until mem_ack.
REQ-008 SHALL have port mem_addr  output  64  byte address of the 32-bit word requested.
REQ-009 SHALL have port mem_ack  input  1  read-data-valid strobe; completes one word.
REQ-010 SHALL have port mem_rdata  input  32  read data, sampled when mem_req&mem_ack.
REQ-011 SHALL have port address_descriptor  output  97  bit96 = End attribute, [95:0] = {word2,word1,word0}.
REQ-012 SHALL have port desc_valid  output  1  address_descriptor valid for the DMA engine.
REQ-013 SHALL have port desc_ready  input  1  DMA engine accepts descriptor when desc_valid&desc_ready.
REQ-014 SHALL have ports busy, done, desc_error  output  1 each  walk active / walk-finished pulse / error pulse.

Function
REQ-015 SHALL decode word0: [0] Valid, [1] End, [5:4] Act (00 nop, 01 reserved, 10 tran, 11 link), [31:16] length; word1/word2 = address low/high.
REQ-016 SHALL implement states IDLE, FETCH0, FETCH1, FETCH2, CHECK, OUTPUT, PAUSED, with busy=1 in all but IDLE and PAUSED.
REQ-017 SHALL, in IDLE or PAUSED, on command_reg_write load pointer=starting_address and enter FETCH0 next cycle.
REQ-018 SHALL in FETCHn drive mem_req=1, mem_addr=pointer+4n, capture word n on mem_ack, advance one state; one cycle minimum per word.
REQ-019 SHALL in CHECK (one cycle) go: Valid=0 or Act=01 -> pulse desc_error, IDLE; link -> pointer={word2,word1}, FETCH0; nop -> End ? done pulse, IDLE : pointer+=12, FETCH0; tran -> OUTPUT.
REQ-020 SHALL in OUTPUT hold desc_valid=1 and address_descriptor stable until desc_ready; on handshake go End ? (done pulse, IDLE) : (pointer+=12, FETCH0).
REQ-021 SHALL compute pointer arithmetic modulo 2^64 (0xFFFF_FFFF_FFFF_FFFC+12 wraps to 0x8).
REQ-022 SHALL, when STOP=1 in any busy state, drop mem_req/desc_valid the same cycle, enter PAUSED next cycle, keep pointer at the start of the current descriptor.
REQ-023 SHALL in PAUSED on command_reg_continue with STOP=0 re-enter FETCH0 at the saved pointer; continue in IDLE is ignored.
REQ-024 SHALL give command_reg_write priority over command_reg_continue when both arrive; command_reg_write while busy is ignored.
REQ-025 SHALL keep done and desc_error one-cycle pulses, never both in the same cycle.

Reset
REQ-026 SHALL on RESET=1 immediately force IDLE, pointer=0, address_descriptor=0, mem_addr=0, mem_req=0, desc_valid=0, busy=0, done=0, desc_error=0.
REQ-027 SHALL abandon any outstanding memory read on reset; mem_ack during reset is ignored.

Configuration
REQ-028 SHALL, when ADMA_LINK_LIMIT_EN is defined, count consecutive link descriptors (cleared by any nop/tran or start) and on the 9th pulse desc_error and go IDLE.
REQ-029 SHALL, without ADMA_LINK_LIMIT_EN, follow links without limit and contain no link counter.

Verification
REQ-030 SHALL cover: start at 0x1000, one tran descriptor word0=0x0200_0023 -> reads 0x1000/0x1004/0x1008, desc_valid with bit96=1, done pulse after desc_ready.
REQ-031 SHALL cover: link at 0x1000 to 0x0000_0001_0000_2000 -> next read at 0x0000_0001_0000_2000, link never presented on desc_valid.
REQ-032 SHALL cover: word0=0x0000_0020 (Valid=0) -> desc_error pulse, busy=0, no desc_valid.
REQ-033 SHALL cover: STOP during FETCH1 of descriptor at 0x100C -> mem_req drops, PAUSED; continue -> refetch from 0x100C.
REQ-034 SHALL cover: RESET asserted in OUTPUT with desc_ready=0 -> all outputs zero asynchronously, IDLE.
REQ-035 SHALL cover: with ADMA_LINK_LIMIT_EN, nine self-links at 0x2000 -> desc_error on 9th; without macro, walk continues.

Source files
------------

// File: rtl/adma_descriptor_fetch.sv
// ---------------------------------------------------------------------------
// adma_descriptor_fetch
//
// Walks an ADMA descriptor table in memory. Each descriptor is three 32-bit
// words read one per request:
//   word0 : [0] Valid, [1] End, [5:4] Act (00 nop, 01 reserved, 10 tran,
//           11 link), [31:16] length
//   word1 : address low, word2 : address high
// Transfer descriptors are handed to the DMA engine with a valid/ready
// handshake; link descriptors redirect the walk; nop descriptors are skipped.
// STOP pauses the walk at the start of the current descriptor, and
// command_reg_continue resumes it from there.
//
// Ports
//   CLK                   clock, rising edge
//   RESET                 asynchronous active-high reset
//   STOP                  level: abort current descriptor and pause
//   command_reg_write     start pulse, walk begins at starting_address
//   command_reg_continue  resume pulse (PAUSED only)
//   starting_address      byte address of the first descriptor
//   mem_req / mem_addr    word read request, held until mem_ack
//   mem_ack / mem_rdata   read data strobe and data
//   address_descriptor    {End, word2, word1, word0}
//   desc_valid/desc_ready descriptor handshake to the DMA engine
//   busy                  walk active (not IDLE, not PAUSED)
//   done                  one-cycle pulse: walk finished on an End descriptor
//   desc_error            one-cycle pulse: invalid/reserved descriptor
//
// Build option
//   ADMA_LINK_LIMIT_EN    when defined, the ninth consecutive link descriptor
//                         raises desc_error and ends the walk.
// ---------------------------------------------------------------------------
module adma_descriptor_fetch (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        STOP,
  input  logic        command_reg_write,
  input  logic        command_reg_continue,
  input  logic [63:0] starting_address,
  output logic        mem_req,
  output logic [63:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [96:0] address_descriptor,
  output logic        desc_valid,
  input  logic        desc_ready,
  output logic        busy,
  output logic        done,
  output logic        desc_error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH0,
    S_FETCH1,
    S_FETCH2,
    S_CHECK,
    S_OUTPUT,
    S_PAUSED
  } state_e;

  localparam logic [1:0] ACT_NOP  = 2'b00;
  localparam logic [1:0] ACT_RSVD = 2'b01;
  localparam logic [1:0] ACT_TRAN = 2'b10;
  localparam logic [1:0] ACT_LINK = 2'b11;

  localparam logic [63:0] DESC_BYTES = 64'd12;

  state_e      state_q, state_d;
  logic [63:0] pointer_q, pointer_d;   // start of the descriptor being walked
  logic [95:0] words_q, words_d;       // {word2, word1, word0}
  logic [63:0] word_offset;

  logic       d_valid;
  logic       d_end;
  logic [1:0] d_act;

`ifdef ADMA_LINK_LIMIT_EN
  // Eight consecutive links may be followed; the ninth is treated as a loop.
  localparam logic [3:0] LINK_MAX_FOLLOWED = 4'd8;
  logic [3:0] link_cnt_q, link_cnt_d;
`endif

  assign d_valid = words_q[0];
  assign d_end   = words_q[1];
  assign d_act   = words_q[5:4];

  assign word_offset = (state_q == S_FETCH1) ? 64'd4 :
                       (state_q == S_FETCH2) ? 64'd8 : 64'd0;

  assign address_descriptor = {d_end, words_q};
  assign busy               = (state_q != S_IDLE) && (state_q != S_PAUSED);

  always_comb begin
    // NOTE: every variable written here is given a default first, so no path
    // through the case statements can leave one unassigned and infer a latch.
    state_d    = state_q;
    pointer_d  = pointer_q;
    words_d    = words_q;
    mem_req    = 1'b0;
    mem_addr   = '0;
    desc_valid = 1'b0;
    done       = 1'b0;
    desc_error = 1'b0;
`ifdef ADMA_LINK_LIMIT_EN
    link_cnt_d = link_cnt_q;
`endif

    unique case (state_q)
      S_IDLE, S_PAUSED: begin
        // A new start wins over a resume arriving in the same cycle.
        if (command_reg_write) begin
          pointer_d = starting_address;
          state_d   = S_FETCH0;
`ifdef ADMA_LINK_LIMIT_EN
          link_cnt_d = '0;
`endif
        end else if ((state_q == S_PAUSED) && command_reg_continue && !STOP) begin
          state_d = S_FETCH0;
        end
      end

      S_FETCH0, S_FETCH1, S_FETCH2: begin
        mem_addr = pointer_q + word_offset;
        if (STOP) begin
          state_d = S_PAUSED;
        end else begin
          mem_req = 1'b1;
          if (mem_ack) begin
            unique case (state_q)
              S_FETCH0: begin
                words_d[31:0] = mem_rdata;
                state_d       = S_FETCH1;
              end
              S_FETCH1: begin
                words_d[63:32] = mem_rdata;
                state_d        = S_FETCH2;
              end
              S_FETCH2: begin
                words_d[95:64] = mem_rdata;
                state_d        = S_CHECK;
              end
              default: state_d = S_IDLE;
            endcase
          end
        end
      end

      S_CHECK: begin
        if (STOP) begin
          state_d = S_PAUSED;
        end else if (!d_valid || (d_act == ACT_RSVD)) begin
          desc_error = 1'b1;
          state_d    = S_IDLE;
        end else begin
          unique case (d_act)
            ACT_LINK: begin
`ifdef ADMA_LINK_LIMIT_EN
              if (link_cnt_q == LINK_MAX_FOLLOWED) begin
                desc_error = 1'b1;
                state_d    = S_IDLE;
              end else begin
                link_cnt_d = link_cnt_q + 4'd1;
                pointer_d  = words_q[95:32];
                state_d    = S_FETCH0;
              end
`else
              pointer_d = words_q[95:32];
              state_d   = S_FETCH0;
`endif
            end
            ACT_NOP: begin
`ifdef ADMA_LINK_LIMIT_EN
              link_cnt_d = '0;
`endif
              if (d_end) begin
                done    = 1'b1;
                state_d = S_IDLE;
              end else begin
                pointer_d = pointer_q + DESC_BYTES;
                state_d   = S_FETCH0;
              end
            end
            ACT_TRAN: begin
`ifdef ADMA_LINK_LIMIT_EN
              link_cnt_d = '0;
`endif
              state_d = S_OUTPUT;
            end
            default: state_d = S_IDLE;
          endcase
        end
      end

      S_OUTPUT: begin
        // Pointer stays at this descriptor until the handshake, so a pause
        // here re-presents the same transfer on resume.
        if (STOP) begin
          state_d = S_PAUSED;
        end else begin
          desc_valid = 1'b1;
          if (desc_ready) begin
            if (d_end) begin
              done    = 1'b1;
              state_d = S_IDLE;
            end else begin
              pointer_d = pointer_q + DESC_BYTES;
              state_d   = S_FETCH0;
            end
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      pointer_q <= '0;
      words_q   <= '0;
`ifdef ADMA_LINK_LIMIT_EN
      link_cnt_q <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q   <= state_d;
      pointer_q <= pointer_d;
      words_q   <= words_d;
`ifdef ADMA_LINK_LIMIT_EN
      link_cnt_q <= link_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_adma_descriptor_fetch.sv
// ---------------------------------------------------------------------------
// tb_adma_descriptor_fetch
//
// Scoreboard bench for adma_descriptor_fetch. Directed tests push the events
// they expect (word reads, descriptor handshakes, done and error pulses) into
// a queue; an independent monitor pops and compares every event the DUT
// produces. A behavioural memory answers read requests from a sparse array.
// Inputs change on the falling edge; the responder acts 1 time unit later and
// the monitor samples 2 time units after the falling edge.
// ---------------------------------------------------------------------------
module tb_adma_descriptor_fetch;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        STOP = 1'b0;
  logic        command_reg_write = 1'b0;
  logic        command_reg_continue = 1'b0;
  logic [63:0] starting_address = '0;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [96:0] address_descriptor;
  logic        desc_valid;
  logic        desc_ready = 1'b1;
  logic        busy;
  logic        done;
  logic        desc_error;

  adma_descriptor_fetch dut (
    .CLK                  (CLK),
    .RESET                (RESET),
    .STOP                 (STOP),
    .command_reg_write    (command_reg_write),
    .command_reg_continue (command_reg_continue),
    .starting_address     (starting_address),
    .mem_req              (mem_req),
    .mem_addr             (mem_addr),
    .mem_ack              (mem_ack),
    .mem_rdata            (mem_rdata),
    .address_descriptor   (address_descriptor),
    .desc_valid           (desc_valid),
    .desc_ready           (desc_ready),
    .busy                 (busy),
    .done                 (done),
    .desc_error           (desc_error)
  );

  initial forever #5 CLK = ~CLK;

  typedef enum logic [1:0] {EV_READ, EV_DESC, EV_DONE, EV_ERR} ev_kind_e;
  typedef struct packed {
    ev_kind_e    kind;
    logic [96:0] data;
  } ev_t;

  ev_t         exp_q[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] mem [logic [63:0]];
  int          ack_delay = 0;
  int          ack_cnt = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rd(input logic [63:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  task automatic push(input ev_kind_e k, input logic [96:0] d);
    ev_t e;
    e.kind = k;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic push_reads(input logic [63:0] base, input int n);
    for (int i = 0; i < n; i++) push(EV_READ, {33'd0, base + 64'(4 * i)});
  endtask

  task automatic push_desc(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
    push(EV_DESC, {w0[1], w2, w1, w0});
  endtask

  task automatic put_desc(input logic [63:0] a, input logic [31:0] w0,
                          input logic [31:0] w1, input logic [31:0] w2);
    mem[a]          = w0;
    mem[a + 64'd4]  = w1;
    mem[a + 64'd8]  = w2;
  endtask

  // Monitor side: one popped expectation per observed event.
  task automatic observe(input ev_kind_e k, input logic [96:0] d, input string name);
    ev_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: got unexpected event data=%0h expected no event", name, d);
    end else begin
      e = exp_q.pop_front();
      check(name, {k, d}, {e.kind, e.data});
    end
  endtask

  // Memory responder.
  initial forever begin
    @(negedge CLK);
    #1;
    if (mem_req && !RESET) begin
      if (ack_cnt >= ack_delay) begin
        mem_ack   = 1'b1;
        mem_rdata = rd(mem_addr);
        ack_cnt   = 0;
      end else begin
        mem_ack = 1'b0;
        ack_cnt++;
      end
    end else begin
      mem_ack = 1'b0;
      ack_cnt = 0;
    end
  end

  // Monitor.
  initial forever begin
    @(negedge CLK);
    #2;
    if (!RESET) begin
      if (mem_req && mem_ack)      observe(EV_READ, {33'd0, mem_addr}, "read");
      if (desc_valid && desc_ready) observe(EV_DESC, address_descriptor, "desc");
      if (done)                    observe(EV_DONE, '0, "done");
      if (desc_error)              observe(EV_ERR, '0, "desc_error");
      if (done || desc_error)      check("pulse_exclusive", done && desc_error, 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic start(input logic [63:0] a);
    starting_address  = a;
    command_reg_write = 1'b1;
    @(negedge CLK);
    command_reg_write = 1'b0;
  endtask

  task automatic pulse_continue();
    command_reg_continue = 1'b1;
    @(negedge CLK);
    command_reg_continue = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge CLK);
      n++;
    end
    check({name, "_drain"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Wait for the nth cycle requesting addr, then raise STOP before the ack.
  task automatic stop_at_fetch(input string name, input logic [63:0] addr, input int nth);
    int seen = 0;
    int n = 0;
    while (seen < nth && n < 400) begin
      @(negedge CLK);
      n++;
      if (mem_req && mem_addr == addr) seen++;
    end
    STOP = 1'b1;
    check({name, "_reached"}, seen, nth);
  endtask

  initial begin
    // Reset state.
    #1 RESET = 1'b1;
    #2;
    check("reset_flags", {mem_req, desc_valid, busy, done, desc_error}, 0);
    check("reset_mem_addr", mem_addr, 0);
    check("reset_descriptor", address_descriptor, 0);
    @(negedge CLK);
    RESET = 1'b0;
    cyc(1);

    // Single transfer descriptor with End set.
    put_desc(64'h1000, 32'h0200_0023, 32'hAAAA_0001, 32'h0000_0000);
    push_reads(64'h1000, 3);
    push_desc(32'h0200_0023, 32'hAAAA_0001, 32'h0000_0000);
    push(EV_DONE, '0);
    start(64'h1000);
    drain("tran_end", 60);
    check("tran_end_busy", busy, 0);

    // Continue while idle does nothing.
    pulse_continue();
    cyc(3);
    check("continue_idle_busy", busy, 0);

    // Link to a high address; a write while busy is ignored; slow memory.
    ack_delay = 1;
    put_desc(64'h1000, 32'h0000_0031, 32'h0000_2000, 32'h0000_0001);
    put_desc(64'h1_0000_2000, 32'h0004_0023, 32'h1234_5678, 32'h9ABC_DEF0);
    push_reads(64'h1000, 3);
    push_reads(64'h1_0000_2000, 3);
    push_desc(32'h0004_0023, 32'h1234_5678, 32'h9ABC_DEF0);
    push(EV_DONE, '0);
    start(64'h1000);
    cyc(2);
    start(64'h9000);
    check("write_while_busy_busy", busy, 1);
    drain("link", 80);
    ack_delay = 0;

    // Valid=0 descriptor.
    put_desc(64'h1000, 32'h0000_0020, 32'h0, 32'h0);
    push_reads(64'h1000, 3);
    push(EV_ERR, '0);
    start(64'h1000);
    drain("invalid", 60);
    check("invalid_busy", busy, 0);

    // Reserved action.
    put_desc(64'h1000, 32'h0000_0011, 32'h0, 32'h0);
    push_reads(64'h1000, 3);
    push(EV_ERR, '0);
    start(64'h1000);
    drain("reserved", 60);
    check("reserved_busy", busy, 0);

    // Nop without End is skipped, then a transfer.
    put_desc(64'h4000, 32'h0000_0001, 32'h0000_DEAD, 32'h0000_BEEF);
    put_desc(64'h400C, 32'h0000_0023, 32'h0000_0001, 32'h0000_0002);
    put_desc(64'h4018, 32'h0000_0003, 32'h0, 32'h0);
    push_reads(64'h4000, 6);
    push_desc(32'h0000_0023, 32'h0000_0001, 32'h0000_0002);
    push(EV_DONE, '0);
    start(64'h4000);
    drain("nop_skip", 80);

    // Nop with End finishes the walk.
    push_reads(64'h4018, 3);
    push(EV_DONE, '0);
    start(64'h4018);
    drain("nop_end", 60);
    check("nop_end_busy", busy, 0);

    // Pointer arithmetic wraps at 2^64.
    put_desc(64'hFFFF_FFFF_FFFF_FFFC, 32'h0000_0001, 32'h0, 32'h0);
    put_desc(64'h8, 32'h0000_0023, 32'h0000_000C, 32'h0000_0010);
    push(EV_READ, {33'd0, 64'hFFFF_FFFF_FFFF_FFFC});
    push_reads(64'h0, 5);
    push_desc(32'h0000_0023, 32'h0000_000C, 32'h0000_0010);
    push(EV_DONE, '0);
    start(64'hFFFF_FFFF_FFFF_FFFC);
    drain("wrap", 80);

    // STOP during FETCH1 of the second descriptor, then continue.
    ack_delay = 1;
    put_desc(64'h1000, 32'h0010_0021, 32'h0000_5000, 32'h0);
    put_desc(64'h100C, 32'h0000_0023, 32'h0000_6000, 32'h0000_0007);
    push_reads(64'h1000, 3);
    push_desc(32'h0010_0021, 32'h0000_5000, 32'h0);
    push(EV_READ, {33'd0, 64'h100C});
    start(64'h1000);
    stop_at_fetch("stop", 64'h1010, 1);
    #2;
    check("stop_mem_req", mem_req, 0);
    @(negedge CLK);
    check("paused_flags", {busy, mem_req, desc_valid}, 0);
    check("stop_partial", exp_q.size(), 0);
    cyc(3);
    STOP = 1'b0;
    push_reads(64'h100C, 3);
    push_desc(32'h0000_0023, 32'h0000_6000, 32'h0000_0007);
    push(EV_DONE, '0);
    pulse_continue();
    drain("resume", 80);
    ack_delay = 0;

    // Self-linking descriptor.
    put_desc(64'h2000, 32'h0000_0031, 32'h0000_2000, 32'h0);
`ifdef ADMA_LINK_LIMIT_EN
    push_reads(64'h2000, 27);
    push(EV_ERR, '0);
    start(64'h2000);
    drain("link_limit", 200);
    check("link_limit_busy", busy, 0);
`else
    for (int i = 0; i < 10; i++) push_reads(64'h2000, 3);
    push(EV_READ, {33'd0, 64'h2000});
    start(64'h2000);
    stop_at_fetch("self_link", 64'h2004, 11);
    @(negedge CLK);
    check("self_link_paused", busy, 0);
    check("self_link_partial", exp_q.size(), 0);
    STOP = 1'b0;
    // Start and continue together: start wins.
    push_reads(64'h4018, 3);
    push(EV_DONE, '0);
    starting_address     = 64'h4018;
    command_reg_write    = 1'b1;
    command_reg_continue = 1'b1;
    @(negedge CLK);
    command_reg_write    = 1'b0;
    command_reg_continue = 1'b0;
    drain("write_over_continue", 60);
`endif

    // Reset while holding a descriptor in OUTPUT.
    put_desc(64'h1000, 32'h0200_0023, 32'hAAAA_0001, 32'h0000_0000);
    desc_ready = 1'b0;
    push_reads(64'h1000, 3);
    start(64'h1000);
    for (int n = 0; n < 50 && !desc_valid; n++) @(negedge CLK);
    check("output_reached", desc_valid, 1);
    cyc(2);
    check("output_hold", {desc_valid, address_descriptor},
          {1'b1, 1'b1, 32'h0000_0000, 32'hAAAA_0001, 32'h0200_0023});
    check("output_reads", exp_q.size(), 0);
    #3 RESET = 1'b1;
    #1;
    check("async_reset_flags", {mem_req, desc_valid, busy, done, desc_error}, 0);
    check("async_reset_mem_addr", mem_addr, 0);
    check("async_reset_descriptor", address_descriptor, 0);
    @(negedge CLK);
    RESET = 1'b0;
    desc_ready = 1'b1;
    cyc(3);
    check("post_reset_idle", {busy, desc_valid, mem_req}, 0);
    check("post_reset_events", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
